// File: rtl/dcpu_sram_bridge.sv
// rtl/dcpu_sram_bridge.sv - dcpu bus slave serving 16-bit byte-laned cycles from an 8-bit async SRAM
module dcpu_sram_bridge #(
   parameter int ADDR_W = 19,
   parameter int WAIT   = 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_cyc,
   input  logic [1:0]        i_stb,
   input  logic              i_we,
   input  logic [31:0]       i_addr,
   input  logic [15:0]       i_dat,
   output logic [15:0]       o_dat,
   output logic              o_ack,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [7:0]        o_sram_dat,
   output logic              o_sram_dat_oe,
   input  logic [7:0]        i_sram_dat,
   output logic              o_sram_ce_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_we_n
);
   typedef enum logic [1:0] {IDLE, STROBE, RECOVER, ACK} state_t;

   localparam logic [3:0] WAIT_CNT = 4'(WAIT);

   state_t            state, state_nx;
   logic [3:0]        cnt, cnt_nx;
   logic              lane, lane_nx;
   logic [ADDR_W-2:0] addr_q, addr_nx;
   logic              we_q, we_nx;
   logic [15:0]       wdat_q, wdat_nx;
   logic [1:0]        stb_q, stb_nx;
   logic [15:0]       rbuf, rbuf_nx;
   logic              cyc_ok, cyc_ok_nx;

   logic [15:0]       dat_nx;
   logic              ack_nx;
   logic [ADDR_W-1:0] sram_addr_nx;
   logic [7:0]        sram_dat_nx;
   logic              sram_dat_oe_nx;
   logic              ce_n_nx, oe_n_nx, we_n_nx;

   // Upper core address bits alias onto the SRAM; bit 0 is replaced by the lane
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_addr[31:ADDR_W], i_addr[0]};

   // Next-state, transfer context and next registered pin values
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      lane_nx   = lane;
      addr_nx   = addr_q;
      we_nx     = we_q;
      wdat_nx   = wdat_q;
      stb_nx    = stb_q;
      rbuf_nx   = rbuf;
      cyc_ok_nx = cyc_ok;

      unique case (state)
         IDLE: begin
            if (i_cyc && (i_stb != 2'b00)) begin
               state_nx  = STROBE;
               cnt_nx    = 4'd0;
               lane_nx   = ~i_stb[0];
               addr_nx   = i_addr[ADDR_W-1:1];
               we_nx     = i_we;
               wdat_nx   = i_dat;
               stb_nx    = i_stb;
               rbuf_nx   = 16'h0000;
               cyc_ok_nx = 1'b1;
            end
         end
         STROBE: begin
            cyc_ok_nx = cyc_ok & i_cyc;
            if (cnt == WAIT_CNT) begin
               if (we_q) begin
                  state_nx = RECOVER;
               end else begin
                  if (lane) rbuf_nx[15:8] = i_sram_dat;
                  else      rbuf_nx[7:0]  = i_sram_dat;
                  if (!lane && stb_q[1]) begin
                     cnt_nx  = 4'd0;
                     lane_nx = 1'b1;
                  end else begin
                     state_nx = ACK;
                  end
               end
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         RECOVER: begin
            cyc_ok_nx = cyc_ok & i_cyc;
            if (!lane && stb_q[1]) begin
               state_nx = STROBE;
               cnt_nx   = 4'd0;
               lane_nx  = 1'b1;
            end else begin
               state_nx = ACK;
            end
         end
         ACK: begin
            state_nx = IDLE;
         end
      endcase

      // Pins are derived from the next state so they are registered yet aligned with it
      ack_nx         = (state_nx == ACK) && cyc_ok_nx;
      dat_nx         = ((state_nx == ACK) && !we_nx) ? rbuf_nx : 16'h0000;
      ce_n_nx        = (state_nx != STROBE);
      oe_n_nx        = !((state_nx == STROBE) && !we_nx);
      we_n_nx        = !((state_nx == STROBE) && we_nx);
      sram_dat_oe_nx = we_nx && ((state_nx == STROBE) || (state_nx == RECOVER));
      sram_addr_nx   = (state_nx == STROBE) ? {addr_nx, lane_nx} : o_sram_addr;
      sram_dat_nx    = ((state_nx == STROBE) && we_nx) ?
                       (lane_nx ? wdat_nx[15:8] : wdat_nx[7:0]) : o_sram_dat;
   end

   // State and transfer context registers
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         lane   <= 1'b0;
         addr_q <= '0;
         we_q   <= 1'b0;
         wdat_q <= 16'h0000;
         stb_q  <= 2'b00;
         rbuf   <= 16'h0000;
         cyc_ok <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         lane   <= lane_nx;
         addr_q <= addr_nx;
         we_q   <= we_nx;
         wdat_q <= wdat_nx;
         stb_q  <= stb_nx;
         rbuf   <= rbuf_nx;
         cyc_ok <= cyc_ok_nx;
      end
   end

   // Output registers: no combinational path from core inputs to pins or ack
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_ack         <= 1'b0;
         o_dat         <= 16'h0000;
         o_sram_addr   <= '0;
         o_sram_dat    <= 8'h00;
         o_sram_dat_oe <= 1'b0;
         o_sram_ce_n   <= 1'b1;
         o_sram_oe_n   <= 1'b1;
         o_sram_we_n   <= 1'b1;
      end else begin
         o_ack         <= ack_nx;
         o_dat         <= dat_nx;
         o_sram_addr   <= sram_addr_nx;
         o_sram_dat    <= sram_dat_nx;
         o_sram_dat_oe <= sram_dat_oe_nx;
         o_sram_ce_n   <= ce_n_nx;
         o_sram_oe_n   <= oe_n_nx;
         o_sram_we_n   <= we_n_nx;
      end
   end
endmodule

// File: tb/tb_dcpu_sram_bridge.sv
// tb/tb_dcpu_sram_bridge.sv - self-checking bench for dcpu_sram_bridge
`timescale 1ns/1ps
module tb_dcpu_sram_bridge;
   localparam int ADDR_W = 19;
   localparam int WAIT   = 1;
   localparam int MEM_SZ = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_cyc;
   logic [1:0]        i_stb;
   logic              i_we;
   logic [31:0]       i_addr;
   logic [15:0]       i_dat;
   logic [15:0]       o_dat;
   logic              o_ack;
   logic [ADDR_W-1:0] o_sram_addr;
   logic [7:0]        o_sram_dat;
   logic              o_sram_dat_oe;
   logic [7:0]        i_sram_dat;
   logic              o_sram_ce_n;
   logic              o_sram_oe_n;
   logic              o_sram_we_n;

   always #5 clk = ~clk;

   dcpu_sram_bridge #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
      .i_clk(clk), .i_reset(rst), .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we),
      .i_addr(i_addr), .i_dat(i_dat), .o_dat(o_dat), .o_ack(o_ack),
      .o_sram_addr(o_sram_addr), .o_sram_dat(o_sram_dat), .o_sram_dat_oe(o_sram_dat_oe),
      .i_sram_dat(i_sram_dat), .o_sram_ce_n(o_sram_ce_n), .o_sram_oe_n(o_sram_oe_n),
      .o_sram_we_n(o_sram_we_n)
   );

   logic [7:0] sram    [0:MEM_SZ-1];
   logic [7:0] ref_mem [0:MEM_SZ-1];
   int ce_low, ack_cnt, viol;
   int pass_cnt = 0;
   int total_cnt = 0;

   assign i_sram_dat = (!o_sram_ce_n && !o_sram_oe_n) ? sram[o_sram_addr] : 8'hA5;

   // SRAM model plus pin-protocol monitor, sampled 2 ns after each rising edge
   initial begin
      logic              prev_we_low;
      logic [ADDR_W-1:0] prev_addr;
      logic [7:0]        prev_dat;
      prev_we_low = 1'b0; prev_addr = '0; prev_dat = 8'h00;
      ce_low = 0; ack_cnt = 0; viol = 0;
      for (int i = 0; i < MEM_SZ; i++) sram[i] = 8'h00;
      forever begin
         @(posedge clk); #2;
         if (!o_sram_ce_n) ce_low++;
         if (o_ack) ack_cnt++;
         if (!o_sram_oe_n && !o_sram_we_n) viol++;
         if (o_sram_dat_oe && !o_sram_oe_n) viol++;
         if (!o_sram_we_n && (!o_sram_dat_oe || o_sram_ce_n)) viol++;
         if (o_ack && !o_sram_ce_n) viol++;
         if (prev_we_low && o_sram_we_n && o_sram_dat_oe &&
             ((o_sram_addr != prev_addr) || (o_sram_dat != prev_dat))) viol++;
         if (!o_sram_ce_n && !o_sram_we_n) sram[o_sram_addr] = o_sram_dat;
         prev_we_low = !o_sram_we_n;
         prev_addr   = o_sram_addr;
         prev_dat    = o_sram_dat;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_reset_pins(input string name);
      check(name, {o_ack, o_dat, o_sram_addr, o_sram_dat, o_sram_dat_oe, o_sram_ce_n, o_sram_oe_n, o_sram_we_n},
            {1'b0, 16'h0000, 19'h00000, 8'h00, 1'b0, 3'b111});
   endtask

   function automatic int nlanes(input logic [1:0] s);
      return int'(s[0]) + int'(s[1]);
   endfunction

   function automatic int model_lat(input logic we, input logic [1:0] s);
      return we ? nlanes(s) * (WAIT + 2) + 1 : nlanes(s) * (WAIT + 1) + 1;
   endfunction

   function automatic int unsigned word_base(input logic [31:0] addr);
      return (addr % MEM_SZ) & ~32'd1;
   endfunction

   function automatic logic [15:0] model_read(input logic [31:0] addr, input logic [1:0] s);
      int unsigned a;
      a = word_base(addr);
      return {s[1] ? ref_mem[a + 1] : 8'h00, s[0] ? ref_mem[a] : 8'h00};
   endfunction

   // Present a request at the current falling edge, hold it through the ack cycle
   task automatic xfer(input logic we, input logic [31:0] addr, input logic [15:0] d, input logic [1:0] s,
                       input int drop_at, output logic [15:0] rd, output int lat,
                       output int strobes, output int first_ce);
      int ce0;
      ce0 = ce_low; rd = 16'h0000; lat = -1; first_ce = -1;
      i_cyc = 1'b1; i_stb = s; i_we = we; i_addr = addr; i_dat = d;
      for (int k = 1; k <= 4 * (WAIT + 2) + 4; k++) begin
         @(negedge clk);
         if (k == drop_at) i_cyc = 1'b0;
         if (first_ce < 0 && !o_sram_ce_n) first_ce = k;
         if (o_ack) begin
            lat = k;
            rd  = o_dat;
            break;
         end
      end
      @(negedge clk);
      strobes = ce_low - ce0;
   endtask

   task automatic run(input string name, input logic we, input logic [31:0] addr, input logic [15:0] d,
                      input logic [1:0] s, input int drop_at, input logic [15:0] exp_dat, input int exp_lat);
      logic [15:0] rd;
      int lat, strobes, first_ce;
      int unsigned a;
      xfer(we, addr, d, s, drop_at, rd, lat, strobes, first_ce);
      if (drop_at > 0) begin
         check({name, " suppressed ack"}, 64'(lat), 64'(-1));
      end else begin
         check({name, " ack cycle"}, 64'(lat), 64'(exp_lat));
         if (!we) check({name, " read data"}, 64'(rd), 64'(exp_dat));
         check({name, " first strobe cycle"}, 64'(first_ce), 64'(1));
      end
      check({name, " strobe cycles"}, 64'(strobes), 64'(nlanes(s) * (WAIT + 1)));
      if (we) begin
         a = word_base(addr);
         if (s[0]) ref_mem[a]     = d[7:0];
         if (s[1]) ref_mem[a + 1] = d[15:8];
      end
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [15:0] dat;
      logic [1:0]  stb;
      logic [15:0] exp_dat;
      int          exp_lat;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int a0, c0;
      logic        we;
      logic [31:0] addr;
      logic [1:0]  s;
      logic [15:0] d;

      vecs[0] = '{1'b1, 32'h0000_0010, 16'hBEEF, 2'b11, 16'h0000, 7};
      vecs[1] = '{1'b0, 32'h0000_0010, 16'h0000, 2'b11, 16'hBEEF, 5};
      vecs[2] = '{1'b0, 32'h0000_0010, 16'h0000, 2'b10, 16'hBE00, 3};
      vecs[3] = '{1'b0, 32'h0000_0011, 16'h0000, 2'b01, 16'h00EF, 3};
      vecs[4] = '{1'b1, 32'h0008_0002, 16'h1234, 2'b11, 16'h0000, 7};
      vecs[5] = '{1'b0, 32'h0000_0002, 16'h0000, 2'b11, 16'h1234, 5};
      vecs[6] = '{1'b1, 32'h0000_0021, 16'hAA55, 2'b01, 16'h0000, 4};
      vecs[7] = '{1'b0, 32'h0000_0020, 16'h0000, 2'b11, 16'h0055, 5};

      for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = 8'h00;
      rst = 1'b1; i_cyc = 1'b0; i_stb = 2'b00; i_we = 1'b0; i_addr = 32'h0; i_dat = 16'h0;
      repeat (2) @(negedge clk);
      check_reset_pins("reset pins");
      rst = 1'b0;

      // Cycle open but no lanes strobed: nothing may happen
      c0 = ce_low; a0 = ack_cnt;
      i_cyc = 1'b1; i_stb = 2'b00;
      repeat (10) @(negedge clk);
      check("idle no strobe", 64'(ce_low - c0), 64'(0));
      check("idle no ack", 64'(ack_cnt - a0), 64'(0));
      i_cyc = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++)
         run($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].dat, vecs[i].stb, 0,
             vecs[i].exp_dat, vecs[i].exp_lat);
      check("sram 0x10", 64'(sram[32'h10]), 64'(8'hEF));
      check("sram 0x11", 64'(sram[32'h11]), 64'(8'hBE));
      check("alias sram 0x02", 64'(sram[32'h02]), 64'(8'h34));
      check("alias sram 0x03", 64'(sram[32'h03]), 64'(8'h12));
      check("lane1 untouched 0x21", 64'(sram[32'h21]), 64'(8'h00));

      // Back-to-back fetches with the request held through each ack cycle
      a0 = ack_cnt;
      for (int i = 0; i < 3; i++)
         run($sformatf("fetch%0d", i), 1'b0, 32'(2 * i), 16'h0, 2'b11, 0,
             model_read(32'(2 * i), 2'b11), model_lat(1'b0, 2'b11));
      i_cyc = 1'b0; i_stb = 2'b00;
      @(negedge clk);
      check("fetch ack count", 64'(ack_cnt - a0), 64'(3));

      // Cycle dropped mid-transfer: ack suppressed, write still lands
      run("dropped write", 1'b1, 32'h30, 16'h7788, 2'b11, 2, 16'h0, 0);
      i_cyc = 1'b0; i_stb = 2'b00;
      @(negedge clk);
      run("read after drop", 1'b0, 32'h30, 16'h0, 2'b11, 0, 16'h7788, 5);
      i_cyc = 1'b0; i_stb = 2'b00;
      @(negedge clk);

      // Asynchronous reset inside lane 0 strobe of a two-lane write
      a0 = ack_cnt;
      i_cyc = 1'b1; i_stb = 2'b11; i_we = 1'b1; i_addr = 32'h40; i_dat = 16'hC3A5;
      @(negedge clk);
      check("write strobe active", 64'(o_sram_we_n), 64'(0));
      #2 rst = 1'b1;
      #1 check_reset_pins("async reset pins");
      i_cyc = 1'b0; i_stb = 2'b00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("abandoned lane1", 64'(sram[32'h41]), 64'(8'h00));
      check("abandoned no ack", 64'(ack_cnt - a0), 64'(0));
      run("post reset read", 1'b0, 32'h10, 16'h0, 2'b11, 0, 16'hBEEF, 5);
      i_cyc = 1'b0; i_stb = 2'b00;
      @(negedge clk);

      // Randomized traffic in 0x100..0x1FF with random alias bits, checked against the model
      for (int n = 0; n < 60; n++) begin
         we   = 1'($urandom_range(0, 1));
         s    = 2'($urandom_range(1, 3));
         d    = 16'($urandom);
         addr = ($urandom & 32'hFFF8_0000) | 32'h100 | 32'($urandom_range(0, 255));
         run($sformatf("rand%0d", n), we, addr, d, s, 0, model_read(addr, s), model_lat(we, s));
         if ($urandom_range(0, 2) == 0) begin
            i_cyc = 1'b0; i_stb = 2'b00;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      i_cyc = 1'b0; i_stb = 2'b00;
      repeat (2) @(negedge clk);
      check("pin protocol violations", 64'(viol), 64'(0));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/dcpu_sram_bridge.md
Name: dcpu_sram_bridge

Overview:
Bus slave directly downstream of the dcpu core. It serves the core's 16-bit byte-laned bus cycles (instruction fetch, load, store) against an external 8-bit asynchronous SRAM. Each enabled byte lane becomes one timed SRAM access, and the slave returns a single-cycle ack once all lanes are done. The configurable wait-state count lets the same RTL drive slow and fast SRAM parts.

Parameters:
ADDR_W, 19, SRAM byte-address width; core address bits above ADDR_W-1 are ignored, so memory aliases.
WAIT, 1, extra strobe cycles per byte access; legal range 0..15.

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_cyc  in  1  bus cycle active
i_stb  in  2  byte-lane strobes: [0] = byte at even address (bits 7:0), [1] = byte at odd address (bits 15:8)
i_we  in  1  1 = write, 0 = read
i_addr  in  32  byte address; bit 0 ignored
i_dat  in  16  write data
o_dat  out  16  read data, valid while o_ack=1
o_ack  out  1  one-cycle transfer acknowledge
o_sram_addr  out  ADDR_W  SRAM byte address
o_sram_dat  out  8  SRAM write data
o_sram_dat_oe  out  1  top-level tristate enable for o_sram_dat
i_sram_dat  in  8  SRAM read data
o_sram_ce_n  out  1  chip enable, active-low
o_sram_oe_n  out  1  output enable, active-low
o_sram_we_n  out  1  write enable, active-low

Behaviour:
- Reset (asynchronous, active-high; takes effect at any time, including mid-transfer) forces state IDLE and all outputs to these values: o_ack=0, o_dat=0, o_sram_addr=0, o_sram_dat=0, o_sram_dat_oe=0, ce_n=oe_n=we_n=1. An interrupted SRAM write is abandoned; no ack is issued for it.
- State machine states: IDLE, STROBE, RECOVER, ACK.
- IDLE: a request is accepted when i_cyc=1 and i_stb!=0. On acceptance, latch i_addr, i_we, i_dat and i_stb, clear the read buffer, select the lowest enabled lane, and go to STROBE. When i_stb=0 nothing is accepted.
- STROBE lasts WAIT+1 cycles and is timed by a 4-bit counter.
  - During STROBE: o_sram_addr = {latched_addr[ADDR_W-1:1], lane}, ce_n=0.
  - Read: oe_n=0. On the last STROBE cycle, capture i_sram_dat into byte `lane` of the read buffer.
  - Write: we_n=0, o_sram_dat = the latched byte for that lane, o_sram_dat_oe=1.
- After STROBE:
  - Read: if lane 1 is still pending, start STROBE on lane 1 directly. Otherwise go to ACK.
  - Write: go to RECOVER.
- RECOVER (writes only) lasts 1 cycle. we_n=1 and ce_n=1, while address, data and dat_oe are held (address/data hold time). Then go to STROBE for lane 1 if it is pending, else to ACK.
- ACK lasts 1 cycle. All SRAM strobes are inactive.
  - o_ack = latched i_cyc && i_cyc. If i_cyc dropped during the transfer, the ack is suppressed; the SRAM access still completes.
  - o_dat = read buffer (lanes that were not read = 0x00); o_dat = 0 for writes.
  - Next state is IDLE. The request present during the ACK cycle is never re-accepted.
- Back-to-back requests: a new request may be accepted in the first IDLE cycle after ACK. Minimum one IDLE cycle between transfers.
- Latency: the acceptance cycle is cycle 0.
  - Single-lane read: ack in cycle WAIT+2.
  - Two-lane read: ack in cycle 2*(WAIT+1)+1.
  - Single-lane write: ack in cycle WAIT+3.
  - Two-lane write: ack in cycle 2*(WAIT+2)+1.
- oe_n and we_n are never both low. o_sram_dat_oe is 1 only while a write is in STROBE or RECOVER.
- All outputs are registered: no combinational path from core inputs to SRAM pins or to o_ack.

Test Plan:
1. Reset, then idle: all outputs at their reset values; i_stb=0 with i_cyc=1 for 10 cycles -> no SRAM strobe and no ack.
2. WAIT=1, write 0xBEEF to addr 0x00000010 with stb=11 -> SRAM byte 0x10=0xEF, 0x11=0xBE; we_n low 2 cycles per lane; ack in cycle 7.
3. WAIT=1, read addr 0x10 with stb=11 -> o_dat=0xBEEF during ack in cycle 5; oe_n low in cycles 1-4. Read with stb=10 -> o_dat=0xBE00, ack in cycle 3.
4. Back-to-back: core fetch sequence at addrs 0,2,4 held until ack -> exactly one ack and one SRAM access per request; no duplicate access in the ACK cycle.
5. Aliasing: ADDR_W=19, write 0x1234 to addr 0x00080002 -> SRAM address 0x00002 is written.
6. Async reset asserted mid-STROBE of a 2-lane write -> outputs reach reset values without a clock edge, lane 1 is never written, no ack; the next request after reset completes normally.
